lc3_pipeline_controller: RTL and testbench

Central sequencer for the 5-stage LC-3 pipeline (fetch, decode, execute, memaccess, writeback).
- Produces the stage enables, branch-taken flag, operand bypass selects and memory-access state carried on the controller_out bus.
- Fills the pipeline after reset and stalls it for memory access, instruction-memory wait and control hazards.
- Detects register hazards and selects bypass paths.

---
 rtl/lc3_ctrl_pkg.sv | 75 +++++++
 rtl/lc3_pipeline_controller_hazard.sv | 37 +++
 rtl/lc3_pipeline_controller.sv | 188 ++++++++++++++++++
 tb/tb_lc3_pipeline_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// LC-3 pipeline controller shared types.
// Opcodes, FSM/mem-state enums, opcode group helpers.
package lc3_ctrl_pkg;

  typedef enum logic [1:0] {
    MS_READ     = 2'd0,
    MS_IND_READ = 2'd1,
    MS_WRITE    = 2'd2,
    MS_IDLE     = 2'd3
  } mem_state_e;

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_IND,
    S_MEM_RW,
    S_BR_STALL
  } state_e;

  localparam logic [3:0] OP_BR  = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_LD  = 4'd2;
  localparam logic [3:0] OP_ST  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_LDR = 4'd6;
  localparam logic [3:0] OP_STR = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd9;
  localparam logic [3:0] OP_LDI = 4'd10;
  localparam logic [3:0] OP_STI = 4'd11;
  localparam logic [3:0] OP_JMP = 4'd12;

  function automatic logic [3:0] opc(
    input logic [15:0] i
  );
    return i[15:12];
  endfunction

  function automatic logic is_alu(
    input logic [15:0] i
  );
    return (opc(i) == OP_ADD) ||
           (opc(i) == OP_AND) ||
           (opc(i) == OP_NOT);
  endfunction

  function automatic logic is_load(
    input logic [15:0] i
  );
    return (opc(i) == OP_LD) ||
           (opc(i) == OP_LDR) ||
           (opc(i) == OP_LDI);
  endfunction

  function automatic logic is_store(
    input logic [15:0] i
  );
    return (opc(i) == OP_ST) ||
           (opc(i) == OP_STR) ||
           (opc(i) == OP_STI);
  endfunction

  function automatic logic is_ctrl(
    input logic [15:0] i
  );
    return (opc(i) == OP_BR) ||
           (opc(i) == OP_JMP);
  endfunction

  function automatic logic is_ind(
    input logic [15:0] i
  );
    return (opc(i) == OP_LDI) ||
           (opc(i) == OP_STI);
  endfunction

endpackage

// File: rtl/lc3_pipeline_controller_hazard.sv
// LC-3 operand bypass selection.
// Pure combinational match of decode sources vs producers.
module lc3_hazard_unit
  import lc3_ctrl_pkg::*;
(
  input  logic [15:0] ir_i,
  input  logic [15:0] ir_exec_i,
  input  logic        ld_valid_i,
  input  logic [2:0]  ld_dst_i,
  output logic        alu1_o,
  output logic        alu2_o,
  output logic        mem1_o,
  output logic        mem2_o
);

  logic use1;
  logic use2;
  logic ex_alu;

  // ALU result wins over the older load data
  always_comb begin
    use1   = is_alu(ir_i) | is_load(ir_i) |
             is_store(ir_i);
    use2   = ((opc(ir_i) == OP_ADD) |
              (opc(ir_i) == OP_AND)) & ~ir_i[5];
    ex_alu = is_alu(ir_exec_i);
    alu1_o = ex_alu & use1 &
             (ir_i[8:6] == ir_exec_i[11:9]);
    alu2_o = ex_alu & use2 &
             (ir_i[2:0] == ir_exec_i[11:9]);
    mem1_o = ld_valid_i & use1 &
             (ir_i[8:6] == ld_dst_i) & ~alu1_o;
    mem2_o = ld_valid_i & use2 &
             (ir_i[2:0] == ld_dst_i) & ~alu2_o;
  end

endmodule

// File: rtl/lc3_pipeline_controller.sv
// LC-3 five-stage pipeline sequencer.
// Fill, memory/branch stalls, stage enables, bypass.
module lc3_pipeline_controller
  import lc3_ctrl_pkg::*;
#(
  parameter int BR_STALL_CYCLES = 2,
  parameter int FILL_DEPTH      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_data,
  input  logic        complete_instr,
  input  logic [15:0] IMem_dout,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state
);

  localparam int FW = $clog2(FILL_DEPTH + 1);
  localparam int CW = $clog2(BR_STALL_CYCLES + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic           brret_q, brret_d;
  logic           jmp_q, jmp_d;
  logic           ld_q, ld_d;
  logic           taken_q, taken_d;
  logic           bubble_q, bubble_d;
  logic           done_q, done_d;
  logic           ldv_q, ldv_d;
  logic [2:0]     ldst_q, ldst_d;

  logic           f_dec, f_ex, f_wb;
  logic           ldst_exec;
  logic           mem_hit, br_hit;
  mem_state_e     ms;

  assign f_dec     = fill_q >= FW'(1);
  assign f_ex      = fill_q >= FW'(2);
  assign f_wb      = fill_q >= FW'(FILL_DEPTH);
  assign ldst_exec = is_load(IR_Exec) |
                     is_store(IR_Exec);
  assign br_taken  = taken_q;
  assign mem_state = ms;

  // State and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      fill_q   <= '0;
      brret_q  <= 1'b0;
      jmp_q    <= 1'b0;
      ld_q     <= 1'b0;
      taken_q  <= 1'b0;
      bubble_q <= 1'b0;
      done_q   <= 1'b0;
      ldv_q    <= 1'b0;
      ldst_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      brret_q  <= brret_d;
      jmp_q    <= jmp_d;
      ld_q     <= ld_d;
      taken_q  <= taken_d;
      bubble_q <= bubble_d;
      done_q   <= done_d;
      ldv_q    <= ldv_d;
      ldst_q   <= ldst_d;
    end
  end

  // Next-state and stage enables
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    fill_d           = fill_q;
    brret_d          = brret_q;
    jmp_d            = jmp_q;
    ld_d             = ld_q;
    taken_d          = 1'b0;
    bubble_d         = 1'b0;
    done_d           = 1'b0;
    ldv_d            = 1'b0;
    ldst_d           = ldst_q;
    mem_hit          = 1'b0;
    br_hit           = 1'b0;
    enable_updatePC  = 1'b0;
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    ms               = MS_IDLE;
    unique case (state_q)
      S_RUN: begin
        enable_updatePC  = complete_instr;
        enable_fetch     = complete_instr;
        enable_decode    = complete_instr & f_dec;
        enable_execute   = f_ex & ~bubble_q;
        enable_writeback = f_wb;
        br_hit  = complete_instr &
                  is_ctrl(IMem_dout);
        mem_hit = enable_execute & ldst_exec &
                  ~done_q;
        if (complete_instr && !f_wb)
          fill_d = fill_q + FW'(1);
        if (br_hit) begin
          cnt_d = '0;
          jmp_d = opc(IMem_dout) == OP_JMP;
        end
        if (mem_hit) begin
          state_d = is_ind(IR_Exec) ?
                    S_MEM_IND : S_MEM_RW;
          ld_d    = is_load(IR_Exec);
          brret_d = br_hit;
        end else if (br_hit) begin
          state_d = S_BR_STALL;
        end
      end
      S_BR_STALL: begin
        enable_decode    = f_dec;
        enable_execute   = f_ex;
        enable_writeback = f_wb;
        mem_hit = enable_execute & ldst_exec &
                  ~done_q;
        if (mem_hit) begin
          state_d = is_ind(IR_Exec) ?
                    S_MEM_IND : S_MEM_RW;
          ld_d    = is_load(IR_Exec);
          brret_d = 1'b1;
        end else if (cnt_q ==
                     CW'(BR_STALL_CYCLES - 1)) begin
          state_d  = S_RUN;
          taken_d  = jmp_q | (|(NZP & psr));
          bubble_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MEM_IND: begin
        ms = MS_IND_READ;
        if (complete_data)
          state_d = S_MEM_RW;
      end
      S_MEM_RW: begin
        ms = ld_q ? MS_READ : MS_WRITE;
        if (complete_data) begin
          enable_writeback = ld_q;
          state_d = brret_q ? S_BR_STALL : S_RUN;
          brret_d = 1'b0;
          done_d  = 1'b1;
          if (ld_q) begin
            ldv_d  = 1'b1;
            ldst_d = IR_Exec[11:9];
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  lc3_hazard_unit u_hazard (
    .ir_i       (IR),
    .ir_exec_i  (IR_Exec),
    .ld_valid_i (ldv_q),
    .ld_dst_i   (ldst_q),
    .alu1_o     (bypass_alu_1),
    .alu2_o     (bypass_alu_2),
    .mem1_o     (bypass_mem_1),
    .mem2_o     (bypass_mem_2)
  );

endmodule

// File: tb/tb_lc3_pipeline_controller.sv
// Scoreboard bench for lc3_pipeline_controller.
// Stimulus queues expected outputs; monitor compares.
module tb_lc3_pipeline_controller;

  logic        clock;
  logic        reset;
  logic        complete_data;
  logic        complete_instr;
  logic [15:0] IMem_dout;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic [2:0]  psr;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [1:0]  mem_state;

  lc3_pipeline_controller dut (
    .clock            (clock),
    .reset            (reset),
    .complete_data    (complete_data),
    .complete_instr   (complete_instr),
    .IMem_dout        (IMem_dout),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .NZP              (NZP),
    .psr              (psr),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2),
    .bypass_mem_1     (bypass_mem_1),
    .bypass_mem_2     (bypass_mem_2),
    .mem_state        (mem_state)
  );

  // {upc,fetch,dec,ex,wb,taken,a1,a2,m1,m2,ms[1:0]}
  typedef struct {
    int          cyc;
    string       tag;
    logic [11:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [11:0] obs;

  assign obs = {enable_updatePC, enable_fetch,
                enable_decode, enable_execute,
                enable_writeback, br_taken,
                bypass_alu_1, bypass_alu_2,
                bypass_mem_1, bypass_mem_2,
                mem_state};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [11:0] exp);
    exp_t e;
    e.cyc = cyc;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Monitor: pop expectations due this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (sb_q.size() != 0 &&
             sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          failures++;
          $display("FAIL %s stale cyc=%0d now=%0d",
                   e.tag, e.cyc, cyc);
        end else if (obs !== e.exp) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%03h exp=%03h",
                   e.tag, cyc, obs, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    reset = 1'b1;
    complete_data = 1'b0;
    complete_instr = 1'b1;
    IMem_dout = 16'h1000;
    IR = 16'h0000;
    IR_Exec = 16'h0000;
    NZP = 3'b000;
    psr = 3'b000;
    step();
    step();
    reset = 1'b0;
    chk("rst", 12'hC03);
    step(); chk("fill_dec", 12'hE03);
    step(); chk("fill_ex", 12'hF03);
    step(); chk("fill_wb", 12'hF83);

    step(); IR_Exec = 16'h1283; IR = 16'h5441;
    chk("alu_both", 12'hFB3);
    step(); IR = 16'h5461; chk("alu_imm", 12'hFA3);
    step(); IR = 16'h14C1; chk("alu_sr2", 12'hF93);
    step(); IR = 16'h1E00; chk("alu_none", 12'hF83);
    step(); IR_Exec = 16'h0000; IR = 16'h0000;
    complete_instr = 1'b0;
    chk("iwait", 12'h183);
    step(); complete_instr = 1'b1;
    chk("iwait_end", 12'hF83);

    step(); IR_Exec = 16'hA600; chk("ldi_ex", 12'hF83);
    step(); chk("ldi_ind0", 12'h001);
    step(); chk("ldi_ind1", 12'h001);
    step(); complete_data = 1'b1;
    chk("ldi_ind2", 12'h001);
    step(); complete_data = 1'b0;
    chk("ldi_rd0", 12'h000);
    step(); chk("ldi_rd1", 12'h000);
    step(); complete_data = 1'b1;
    chk("ldi_rd2", 12'h080);
    step(); complete_data = 1'b0;
    chk("ldi_done", 12'hF83);
    step(); IR_Exec = 16'h0000;
    chk("ldi_after", 12'hF83);

    step(); IMem_dout = 16'h0400;
    NZP = 3'b010; psr = 3'b010;
    chk("br_t", 12'hF83);
    step(); IMem_dout = 16'h1000; chk("br_t1", 12'h383);
    step(); chk("br_t2", 12'h383);
    step(); chk("br_t3_taken", 12'hEC3);
    step(); chk("br_t4", 12'hF83);

    step(); IMem_dout = 16'h0400; psr = 3'b100;
    chk("brn_t", 12'hF83);
    step(); IMem_dout = 16'h1000; chk("brn_t1", 12'h383);
    step(); chk("brn_t2", 12'h383);
    step(); chk("brn_t3", 12'hE83);
    step(); chk("brn_t4", 12'hF83);

    step(); IMem_dout = 16'hC000; NZP = 3'b000;
    chk("jmp_t", 12'hF83);
    step(); IMem_dout = 16'h1000; chk("jmp_t1", 12'h383);
    step(); chk("jmp_t2", 12'h383);
    step(); chk("jmp_t3_taken", 12'hEC3);
    step(); chk("jmp_t4", 12'hF83);

    step(); IR_Exec = 16'h3000; chk("st_ex", 12'hF83);
    step(); chk("st_wr0", 12'h002);
    step(); complete_data = 1'b1; chk("st_wr1", 12'h002);
    step(); complete_data = 1'b0; chk("st_done", 12'hF83);
    step(); IR_Exec = 16'h0000; chk("st_after", 12'hF83);

    step(); IR_Exec = 16'h6800; chk("ldr_ex", 12'hF83);
    step(); complete_data = 1'b1; chk("ldr_rd", 12'h080);
    step(); complete_data = 1'b0; IR = 16'h1B04;
    chk("mem_byp", 12'hF8F);
    step(); IR_Exec = 16'h0000;
    chk("mem_byp_gone", 12'hF83);

    step(); IR = 16'h0000; IR_Exec = 16'h6800;
    chk("ldr2_ex", 12'hF83);
    step(); complete_data = 1'b1; chk("ldr2_rd", 12'h080);
    step(); complete_data = 1'b0;
    IR_Exec = 16'h1800; IR = 16'h1B04;
    chk("alu_over_mem", 12'hFB3);
    step(); IR_Exec = 16'h0000; IR = 16'h0000;
    chk("idle", 12'hF83);

    step(); IR_Exec = 16'hA600; chk("ldi2_ex", 12'hF83);
    step(); chk("ldi2_ind", 12'h001);
    step(); reset = 1'b1;
    step(); reset = 1'b0; IR_Exec = 16'h0000;
    chk("rst_mid", 12'hC03);
    step(); chk("rst_mid_fill", 12'hE03);

    step();
    step();
    if (sb_q.size() != 0) begin
      failures += sb_q.size();
      $display("FAIL scoreboard left=%0d exp=0",
               sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
